// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory read arbiter.
//   state_e  : controller states (idle, memory read in flight, response cycle)
//   rr_pick  : round-robin winner search, returns {found, index}
//   Def*     : default parameter values
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StResp
  } state_e;

  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefTimeout   = 15;

  // Widest requester set supported; callers zero-extend into these widths.
  localparam int unsigned MaxReq  = 16;
  localparam int unsigned MaxIdxW = 4;

  // First set bit of req searching upward from last+1, wrapping at num_req.
  function automatic logic [MaxIdxW:0] rr_pick(input logic [MaxReq-1:0]  req,
                                               input logic [MaxIdxW-1:0] last,
                                               input int unsigned        num_req);
    logic [MaxIdxW:0] res;
    int unsigned      cand;
    res = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      cand = (32'(last) + k) % num_req;
      if (k <= num_req && !res[MaxIdxW] && req[cand[MaxIdxW-1:0]]) begin
        res = {1'b1, cand[MaxIdxW-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
//   i_req   : request vector
//   i_last  : index of the previously served requester
//   o_idx   : winning index (valid when o_found)
//   o_found : at least one request is pending
module rr_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [MaxIdxW:0] w_pick;
  logic             w_unused_hi;

  assign w_pick  = rr_pick(MaxReq'(i_req), MaxIdxW'(i_last), NUM_REQ);
  assign o_found = w_pick[MaxIdxW];
  assign o_idx   = w_pick[IDX_W-1:0];

  // Index bits above IDX_W are always zero for NUM_REQ requesters.
  assign w_unused_hi = ^(w_pick[MaxIdxW-1:0] >> IDX_W);

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one memory read port between NUM_REQ clients.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_req, i_req_addr  : per-client read request and packed addresses
//   o_gnt              : one-hot grant held for the whole transaction
//   o_rsp_valid        : one-cycle response strobe to the granted client
//   o_rsp_data/error   : response word / timeout flag, held until next response
//   o_mem_read/addr    : memory read strobe and address
//   i_data_ready/bus   : memory data-valid and read data
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_error,
  output logic                          o_mem_read,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  input  logic                          i_data_ready,
  input  logic [DATA_WIDTH-1:0]         i_data_bus
);

  localparam int unsigned        IDX_W   = $clog2(NUM_REQ);
  localparam logic [7:0]         TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  state_e                r_state, w_state_next;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt_next;
  logic [NUM_REQ-1:0]    r_rsp_valid, w_rsp_valid_next;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_next;
  logic                  r_rsp_error, w_rsp_error_next;
  logic                  r_mem_read, w_mem_read_next;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
  logic [7:0]            r_cnt, w_cnt_next;
  logic [IDX_W-1:0]      r_last, w_last_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_win_found;

  rr_select #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_select (
    .i_req  (i_req),
    .i_last (r_last),
    .o_idx  (w_win_idx),
    .o_found(w_win_found)
  );

  always_comb begin
    w_state_next     = r_state;
    w_gnt_next       = r_gnt;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_error_next = r_rsp_error;
    w_mem_read_next  = r_mem_read;
    w_mem_addr_next  = r_mem_addr;
    w_cnt_next       = r_cnt;
    w_last_next      = r_last;
    w_idx_next       = r_idx;
    unique case (r_state)
      StIdle: begin
        if (w_win_found) begin
          w_state_next    = StRead;
          w_idx_next      = w_win_idx;
          w_gnt_next      = ONE << w_win_idx;
          w_mem_read_next = 1'b1;
          // Address is captured here only; later req_addr changes are ignored.
          w_mem_addr_next = i_req_addr[32'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          w_cnt_next      = '0;
        end
      end
      StRead: begin
        // Data beats the timeout when both land on the same edge.
        if (i_data_ready) begin
          w_state_next     = StResp;
          w_rsp_data_next  = i_data_bus;
          w_rsp_error_next = 1'b0;
          w_rsp_valid_next = ONE << r_idx;
          w_mem_read_next  = 1'b0;
        end else if (r_cnt == TO_LAST) begin
          w_state_next     = StResp;
          w_rsp_data_next  = '0;
          w_rsp_error_next = 1'b1;
          w_rsp_valid_next = ONE << r_idx;
          w_mem_read_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      StResp: begin
        w_state_next     = StIdle;
        w_gnt_next       = '0;
        w_rsp_valid_next = '0;
        w_last_next      = r_idx;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_error <= w_rsp_error_next;
      r_mem_read  <= w_mem_read_next;
      r_mem_addr  <= w_mem_addr_next;
      r_cnt       <= w_cnt_next;
      r_last      <= w_last_next;
      r_idx       <= w_idx_next;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_error = r_rsp_error;
  assign o_mem_read  = r_mem_read;
  assign o_mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_error;
  logic            mem_read;
  logic [AW-1:0]   mem_addr;
  logic            data_ready;
  logic [DW-1:0]   data_bus;

  mem_read_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_addr  (req_addr),
    .o_gnt       (gnt),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_error (rsp_error),
    .o_mem_read  (mem_read),
    .o_mem_addr  (mem_addr),
    .i_data_ready(data_ready),
    .i_data_bus  (data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who owns the port, how many read cycles it has waited,
  // and whether its answer is being presented this cycle.
  int            m_owner;
  int            m_waited;
  bit            m_answered;
  int            m_last;
  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_vld;
  logic [DW-1:0] e_data;
  logic          e_err;
  logic          e_rd;
  logic [AW-1:0] e_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N*AW-1:0] ad,
                            input bit dr, input logic [DW-1:0] d);
    if (r) begin
      m_owner = -1; m_waited = 0; m_answered = 0; m_last = N - 1;
      e_gnt = '0; e_vld = '0; e_data = '0; e_err = 1'b0; e_rd = 1'b0; e_addr = '0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && rq[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      if (m_owner >= 0) begin
        e_gnt    = N'(1 << m_owner);
        e_rd     = 1'b1;
        e_addr   = ad[m_owner*AW +: AW];
        m_waited = 0;
      end
    end else if (!m_answered) begin
      m_waited++;
      if (dr || m_waited == TO) begin
        e_data     = dr ? d : '0;
        e_err      = !dr;
        e_vld      = N'(1 << m_owner);
        e_rd       = 1'b0;
        m_answered = 1;
      end
    end else begin
      m_last     = m_owner;
      m_owner    = -1;
      m_answered = 0;
      e_gnt      = '0;
      e_vld      = '0;
    end
  endtask

  task automatic check_outputs();
    check_val("gnt", 32'(gnt), 32'(e_gnt));
    check_val("rsp_valid", 32'(rsp_valid), 32'(e_vld));
    check_val("rsp_data", 32'(rsp_data), 32'(e_data));
    check_val("rsp_error", 32'(rsp_error), 32'(e_err));
    check_val("mem_read", 32'(mem_read), 32'(e_rd));
    check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit r, input logic [N-1:0] rq, input bit dr, input logic [DW-1:0] d);
    rst = r; req = rq; data_ready = dr; data_bus = d;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step(r, rq, req_addr, dr, d);
    #1;
  endtask

  logic [N-1:0] exp_ord [5];
  logic [N-1:0] got_ord [5];
  int           got_cyc [5];
  int           n_grants;
  logic [N-1:0] prev_gnt;
  int           rd_cycles;
  int           n_rsp;
  int           pct;

  initial begin
    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '1; data_ready = 1'b0; data_bus = '0;
    req_addr = {8'h44, 8'h33, 8'h22, 8'h11};
    @(posedge clk);
    model_step(1'b1, req, req_addr, 1'b0, '0);
    #1;

    // Reset held with every client requesting; requester 0 wins first.
    cycle(1'b1, 4'hF, 1'b0, 8'h00);
    cycle(1'b1, 4'hF, 1'b0, 8'h00);
    cycle(1'b0, 4'hF, 1'b0, 8'h00);
    check_val("first_gnt", 32'(gnt), 32'h1);
    check_val("first_addr", 32'(mem_addr), 32'h11);
    cycle(1'b0, 4'h0, 1'b1, 8'h77);
    cycle(1'b0, 4'h0, 1'b0, 8'h00);

    // Single request, data on the third read cycle.
    cycle(1'b1, 4'h0, 1'b0, 8'h00);
    req_addr = {8'h00, 8'h3C, 8'h00, 8'h00};
    cycle(1'b0, 4'b0100, 1'b0, 8'h00);
    check_val("single_addr", 32'(mem_addr), 32'h3C);
    req_addr = '0;
    cycle(1'b0, 4'b0100, 1'b0, 8'h00);
    cycle(1'b0, 4'b0100, 1'b0, 8'h00);
    cycle(1'b0, 4'b0100, 1'b1, 8'hA5);
    check_val("single_vld", 32'(rsp_valid), 32'b0100);
    check_val("single_data", 32'(rsp_data), 32'hA5);
    check_val("single_err", 32'(rsp_error), 32'h0);
    check_val("single_rd", 32'(mem_read), 32'h0);
    cycle(1'b0, 4'h0, 1'b0, 8'h00);

    // All clients requesting, memory always ready: strict rotation, 3 cycles each.
    cycle(1'b1, 4'h0, 1'b0, 8'h00);
    n_grants = 0;
    prev_gnt = '0;
    for (int c = 0; c < 15; c++) begin
      cycle(1'b0, 4'hF, 1'b1, 8'hEE);
      if (gnt != '0 && prev_gnt == '0 && n_grants < 5) begin
        got_ord[n_grants] = gnt;
        got_cyc[n_grants] = c;
        n_grants++;
      end
      prev_gnt = gnt;
    end
    check_val("rr_count", 32'(n_grants), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < n_grants) check_val("rr_order", 32'(got_ord[k]), 32'(exp_ord[k]));
      if (k > 0 && k < n_grants) check_val("rr_spacing", 32'(got_cyc[k] - got_cyc[k-1]), 32'd3);
    end
    cycle(1'b0, 4'h0, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 1'b0, 8'h00);

    // Timeout: memory never answers.
    req_addr = {8'h00, 8'h00, 8'h00, 8'h9B};
    cycle(1'b0, 4'b0001, 1'b0, 8'h00);
    rd_cycles = mem_read ? 1 : 0;
    n_rsp = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 4'b0000, 1'b0, 8'hFF);
      if (mem_read) rd_cycles++;
      if (rsp_valid != '0) begin
        n_rsp++;
        check_val("to_vld", 32'(rsp_valid), 32'b0001);
        check_val("to_err", 32'(rsp_error), 32'h1);
        check_val("to_data", 32'(rsp_data), 32'h0);
      end
    end
    check_val("to_rd_cycles", 32'(rd_cycles), 32'd15);
    check_val("to_rsp_count", 32'(n_rsp), 32'd1);

    // Data arrives on the last read cycle: data wins over the timeout.
    cycle(1'b0, 4'b0001, 1'b0, 8'h00);
    for (int c = 0; c < TO - 1; c++) cycle(1'b0, 4'b0000, 1'b0, 8'h00);
    cycle(1'b0, 4'b0000, 1'b1, 8'h5A);
    check_val("late_vld", 32'(rsp_valid), 32'b0001);
    check_val("late_err", 32'(rsp_error), 32'h0);
    check_val("late_data", 32'(rsp_data), 32'h5A);
    cycle(1'b0, 4'h0, 1'b0, 8'h00);

    // Reset in the middle of a read for requester 1.
    cycle(1'b1, 4'h0, 1'b0, 8'h00);
    cycle(1'b0, 4'b0010, 1'b0, 8'h00);
    cycle(1'b0, 4'b0010, 1'b0, 8'h00);
    cycle(1'b1, 4'b0011, 1'b1, 8'h12);
    check_val("rst_vld", 32'(rsp_valid), 32'h0);
    check_val("rst_rd", 32'(mem_read), 32'h0);
    check_val("rst_gnt", 32'(gnt), 32'h0);
    cycle(1'b0, 4'b0011, 1'b0, 8'h00);
    check_val("rst_regrant", 32'(gnt), 32'b0001);

    // Randomized traffic at several memory response rates.
    for (int seg = 0; seg < 3; seg++) begin
      pct = (seg == 0) ? 4 : ((seg == 1) ? 30 : 90);
      for (int c = 0; c < 300; c++) begin
        req_addr = {$urandom(), $urandom()} >> 32;
        req_addr = $urandom();
        cycle(($urandom_range(0, 199) == 0), N'($urandom_range(0, 15)),
              ($urandom_range(0, 99) < pct), DW'($urandom_range(0, 255)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
